// File: rtl/layer_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : layer_stream_ctrl
// Brief    : Captures a parallel neuron frame and either serialises it or
//            reports the argmax (class index and value) of the frame.
// Revision : 1.0
// ============================================================================
module layer_stream_ctrl #(
    parameter int NN        = 30,
    parameter int dataWidth = 16,
    parameter     MODE      = "stream",
    parameter int IDXW      = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    input  logic                    o_ready,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic [IDXW-1:0]         o_idx,
    output logic                    o_last,
    output logic                    busy,
    output logic                    overrun,
    output logic                    partial_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_SCAN   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam bit              c_argmax     = (MODE == "argmax");
    localparam logic [IDXW-1:0] c_last       = IDXW'(NN - 1);
    localparam logic [IDXW-1:0] c_scan_first = (NN > 1) ? IDXW'(1) : '0;
    // A single-element argmax frame needs no scan and goes straight to RESULT.
    localparam state_t          c_cap_state  = !c_argmax ? S_STREAM :
                                               ((NN == 1) ? S_RESULT : S_SCAN);

    state_t                        r_state;
    state_t                        w_next;
    logic [IDXW-1:0]               r_cnt;
    logic signed [dataWidth-1:0]   r_buf [NN];
    logic signed [dataWidth-1:0]   r_max;
    logic [IDXW-1:0]               r_max_idx;
    logic                          r_overrun;
    logic                          r_partial;

    logic w_full;
    logic w_partial;
    logic w_final_hs;
    logic w_capture;

    assign w_full    = &i_valid;
    assign w_partial = (|i_valid) && !w_full;
    // The frame's final handshake frees the buffer in the same edge, so a
    // coincident frame is taken back-to-back instead of being dropped.
    assign w_final_hs = ((r_state == S_STREAM) && o_ready && (r_cnt == c_last)) ||
                        ((r_state == S_RESULT) && o_ready);
    assign w_capture  = w_full && ((r_state == S_IDLE) || w_final_hs);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_valid = 1'b0;
        o_data  = '0;
        o_idx   = '0;
        o_last  = 1'b0;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_next = c_cap_state;
                end
            end
            S_STREAM: begin
                o_valid = 1'b1;
                o_data  = r_buf[r_cnt];
                o_idx   = r_cnt;
                o_last  = (r_cnt == c_last);
                if (o_ready && (r_cnt == c_last)) begin
                    w_next = w_capture ? c_cap_state : S_IDLE;
                end
            end
            S_SCAN: begin
                if (r_cnt == c_last) begin
                    w_next = S_RESULT;
                end
            end
            S_RESULT: begin
                o_valid = 1'b1;
                o_data  = r_max;
                o_idx   = r_max_idx;
                o_last  = 1'b1;
                if (o_ready) begin
                    w_next = w_capture ? c_cap_state : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_overrun <= 1'b0;
            r_partial <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt     <= (c_cap_state == S_SCAN) ? c_scan_first : '0;
                r_max     <= i_data[dataWidth-1:0];
                r_max_idx <= '0;
            end else if ((r_state == S_STREAM) && o_ready && (r_cnt != c_last)) begin
                r_cnt <= r_cnt + IDXW'(1);
            end else if (r_state == S_SCAN) begin
                // Strict compare keeps the lowest index on ties.
                if (r_buf[r_cnt] > r_max) begin
                    r_max     <= r_buf[r_cnt];
                    r_max_idx <= r_cnt;
                end
                if (r_cnt != c_last) begin
                    r_cnt <= r_cnt + IDXW'(1);
                end
            end
            if (w_full && !w_capture) begin
                r_overrun <= 1'b1;
            end
            if (w_partial) begin
                r_partial <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int n = 0; n < NN; n++) begin
                r_buf[n] <= i_data[n*dataWidth +: dataWidth];
            end
        end
    end

    assign overrun     = r_overrun;
    assign partial_err = r_partial;

endmodule
`default_nettype wire

// File: tb/tb_layer_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_stream_ctrl
// Brief    : Scoreboard bench driving a stream and an argmax instance together.
// Revision : 1.0
// ============================================================================
module tb_layer_stream_ctrl;

    localparam int NN = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NN-1:0]    i_valid = '0;
    logic [NN*DW-1:0] i_data = '0;
    logic [1:0]       rdy = 2'b11;
    logic [1:0]       ov, ol, bz, orun, perr;
    logic [DW-1:0]    od [2];
    logic [IW-1:0]    oi [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    layer_stream_ctrl #(.NN(NN), .dataWidth(DW), .MODE("stream"), .IDXW(IW)) u_stream (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy[0]),
        .o_valid(ov[0]), .o_data(od[0]), .o_idx(oi[0]), .o_last(ol[0]),
        .busy(bz[0]), .overrun(orun[0]), .partial_err(perr[0])
    );

    layer_stream_ctrl #(.NN(NN), .dataWidth(DW), .MODE("argmax"), .IDXW(IW)) u_argmax (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(rdy[1]),
        .o_valid(ov[1]), .o_data(od[1]), .o_idx(oi[1]), .o_last(ol[1]),
        .busy(bz[1]), .overrun(orun[1]), .partial_err(perr[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Transaction-level reference: per instance, outstanding results and the
    // number of edges before the head result may be presented.
    exp_t qs[$];
    exp_t qa[$];
    int   pend [2] = '{0, 0};
    int   wt   [2] = '{0, 0};
    logic m_ovr [2] = '{1'b0, 1'b0};
    logic m_perr = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                pend   = '{0, 0};
                wt     = '{0, 0};
                m_ovr  = '{1'b0, 1'b0};
                m_perr = 1'b0;
                qs.delete();
                qa.delete();
            end else begin
                if ((|i_valid) && !(&i_valid)) m_perr = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    logic hs, acc;
                    hs  = (pend[d] > 0) && (wt[d] == 0) && rdy[d];
                    acc = (&i_valid) && ((pend[d] == 0) || (hs && pend[d] == 1));
                    if (hs) pend[d]--;
                    else if (wt[d] > 0) wt[d]--;
                    if ((&i_valid) && !acc) m_ovr[d] = 1'b1;
                    if (acc && d == 0) begin
                        for (int n = 0; n < NN; n++) begin
                            exp_t e;
                            e.data = i_data[n*DW +: DW];
                            e.idx  = IW'(n);
                            e.last = (n == NN - 1);
                            qs.push_back(e);
                        end
                        pend[0] = NN;
                        wt[0]   = 0;
                    end else if (acc) begin
                        exp_t e;
                        e.data = i_data[DW-1:0];
                        e.idx  = '0;
                        e.last = 1'b1;
                        for (int n = 1; n < NN; n++) begin
                            if ($signed(i_data[n*DW +: DW]) > $signed(e.data)) begin
                                e.data = i_data[n*DW +: DW];
                                e.idx  = IW'(n);
                            end
                        end
                        qa.push_back(e);
                        pend[1] = 1;
                        wt[1]   = NN - 1;
                    end
                end
            end
        end
    end

    // Monitor: compares presented outputs with the head of each queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                logic have;
                chk("o_valid", d, {31'd0, ov[d]}, {31'd0, (pend[d] > 0) && (wt[d] == 0)});
                chk("busy", d, {31'd0, bz[d]}, {31'd0, pend[d] > 0});
                chk("overrun", d, {31'd0, orun[d]}, {31'd0, m_ovr[d]});
                chk("partial_err", d, {31'd0, perr[d]}, {31'd0, m_perr});
                if (ov[d]) begin
                    have = (d == 0) ? (qs.size() > 0) : (qa.size() > 0);
                    if (!have) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output dut%0d: got data %h with no expected entry at %0t",
                                 d, od[d], $time);
                    end else begin
                        e = (d == 0) ? qs[0] : qa[0];
                        chk("o_data", d, {16'd0, od[d]}, {16'd0, e.data});
                        chk("o_idx", d, {30'd0, oi[d]}, {30'd0, e.idx});
                        chk("o_last", d, {31'd0, ol[d]}, {31'd0, e.last});
                        if (rdy[d]) begin
                            if (d == 0) void'(qs.pop_front());
                            else        void'(qa.pop_front());
                        end
                    end
                end else begin
                    chk("idle_outputs", d, {13'd0, od[d], oi[d], ol[d]}, 32'd0);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [NN*DW-1:0] f);
        i_valid = '1;
        i_data  = f;
        step();
        i_valid = '0;
    endtask

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'($urandom_range(0, 3));
            3:       return 16'hFFFF - 16'($urandom_range(0, 2));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [NN*DW-1:0] f;
        int               guard;
        step(3);
        rst = 1'b1;
        step();

        // Basic stream / argmax frame with ready held high.
        drive_frame({16'h7FFF, 16'hFFF0, 16'h0020, 16'h0010});
        step(6);

        // Backpressure while element 1 is presented.
        drive_frame({16'h7FFF, 16'hFFF0, 16'h0020, 16'h0010});
        step();
        rdy = 2'b00;
        step(3);
        rdy = 2'b11;
        step(6);

        // Overrun two cycles after capture, then a back-to-back frame.
        drive_frame({16'h7FFF, 16'hFFF0, 16'h0020, 16'h0010});
        step();
        drive_frame({16'd4, 16'd3, 16'd2, 16'd1});
        step(6);
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        step(3);
        drive_frame({16'h0040, 16'h0030, 16'h0020, 16'h0010});
        step(6);

        // Argmax tie and all-minimum frames.
        drive_frame({16'd9, 16'd9, 16'hFFFD, 16'd5});
        step(6);
        drive_frame({16'h8000, 16'h8000, 16'h8000, 16'h8000});
        step(6);

        // Partial frame is ignored, a full frame still works.
        i_valid = 4'b0111;
        i_data  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        step();
        i_valid = '0;
        step(2);
        drive_frame({16'hAAAA, 16'h5555, 16'h0001, 16'hFFFF});
        step(6);

        // Randomised frames, partial frames and backpressure.
        for (int c = 0; c < 600; c++) begin
            int r;
            rdy[0] = ($urandom_range(0, 3) != 0);
            rdy[1] = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < NN; n++) f[n*DW +: DW] = pick();
            r = $urandom_range(0, 99);
            i_data  = f;
            i_valid = (r < 25) ? '1 : ((r < 28) ? NN'($urandom_range(1, 14)) : '0);
            step();
        end
        i_valid = '0;
        rdy     = 2'b11;
        step(8);

        // Reset while element 2 is presented, then a fresh frame.
        drive_frame({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
        step(2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step(2);
        drive_frame({16'h0044, 16'h0033, 16'h0022, 16'h0011});

        guard = 0;
        while ((qs.size() > 0 || qa.size() > 0 || pend[0] > 0 || pend[1] > 0) && guard < 100) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d outstanding expected 0/0", qs.size(), qa.size());
        end
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
